i2c_bus_arbiter: RTL and testbench

Shares the single I2C master controller (mgo/mend/mack/24-bit i2c_data handshake) between several requesters: the power-up audio/video config sequencer, runtime codec volume control and camera register writes. Round-robin grant with per-request NACK retry and a gap between transfers. Sits between the requesters and the I2C controller, on the same 50 kHz control clock.

---
 rtl/i2c_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one I2C master controller with NACK retry.
// Optional WAIT_END watchdog is compiled in when I2C_ARB_TIMEOUT_EN is defined.
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [24*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic [NUM_REQ-1:0]    err,
    output logic                  busy,
    output logic                  mgo,
    output logic [23:0]           i2c_data,
    input  logic                  mend,
    input  logic                  mack
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_END, GAP} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      owner, owner_nxt;
    logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]      sel;
    logic [RW-1:0]      retry_cnt, retry_cnt_nxt;
    logic [GW-1:0]      gap_cnt, gap_cnt_nxt;
    logic               retry, retry_nxt;
    logic [NUM_REQ-1:0] grant_nxt, done_nxt, err_nxt;
    logic               mgo_nxt;
    logic [23:0]        data_nxt;
    logic               timed_out;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            to_cnt <= '0;
        else if (state != WAIT_END)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 16'd1;
    end

    assign timed_out = (state == WAIT_END) &&
                       (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog absent: a hung controller keeps the bus forever.
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    assign busy = (state != IDLE);

    // Lowest rotation offset from rr_ptr wins; scanned high-to-low so it lands last.
    always_comb begin
        int t;
        t   = 0;
        sel = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            t = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[t])
                sel = IW'(t);
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        retry_cnt_nxt = retry_cnt;
        gap_cnt_nxt   = gap_cnt;
        retry_nxt     = retry;
        grant_nxt     = grant;
        done_nxt      = '0;
        err_nxt       = '0;
        mgo_nxt       = mgo;
        data_nxt      = i2c_data;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt      = sel;
                    grant_nxt      = '0;
                    grant_nxt[sel] = 1'b1;
                    retry_cnt_nxt  = '0;
                    retry_nxt      = 1'b0;
                    state_nxt      = LOAD;
                end
            end
            LOAD: begin
                data_nxt  = req_data[owner*24 +: 24];
                mgo_nxt   = 1'b1;
                state_nxt = WAIT_END;
            end
            WAIT_END: begin
                if (mend || timed_out) begin
                    mgo_nxt     = 1'b0;
                    gap_cnt_nxt = '0;
                    retry_nxt   = 1'b0;
                    state_nxt   = GAP;
                    if (mend && mack) begin
                        done_nxt[owner] = 1'b1;
                    end else if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_cnt_nxt = retry_cnt + 1'b1;
                        retry_nxt     = 1'b1;
                    end else begin
                        err_nxt[owner] = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    if (retry) begin
                        state_nxt = LOAD;
                    end else begin
                        grant_nxt  = '0;
                        rr_ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        state_nxt  = IDLE;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            retry_cnt <= '0;
            gap_cnt   <= '0;
            retry     <= 1'b0;
            grant     <= '0;
            done      <= '0;
            err       <= '0;
            mgo       <= 1'b0;
            i2c_data  <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            retry_cnt <= retry_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            retry     <= retry_nxt;
            grant     <= grant_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            mgo       <= mgo_nxt;
            i2c_data  <= data_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: scoreboard bench with a scripted I2C controller model.
// Expected mgo starts and done/err pulses are queued by stimulus, popped by a monitor.
module tb_i2c_bus_arbiter;

    localparam int N = 3;
    localparam logic [23:0] D0  = 24'h34001a;
    localparam logic [23:0] D1  = 24'h1a0a55;
    localparam logic [23:0] D2  = 24'h783c01;
    localparam logic [23:0] D2B = 24'h783c7f;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [24*N-1:0] req_data;
    logic [N-1:0]   grant, done, err;
    logic           busy, mgo, mend, mack;
    logic [23:0]    i2c_data;

    typedef struct {
        int          kind;
        logic [2:0]  vec;
        logic [23:0] data;
        int          gap;
    } exp_t;

    typedef struct {
        int   dly;
        logic ack;
    } rsp_t;

    exp_t eq[$];
    rsp_t rq[$];
    int   checks;
    int   errors;

    i2c_bus_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .busy(busy),
        .mgo(mgo), .i2c_data(i2c_data), .mend(mend), .mack(mack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_go(input logic [2:0] v, input logic [23:0] d, input int gap);
        exp_t e;
        e.kind = 0; e.vec = v; e.data = d; e.gap = gap;
        eq.push_back(e);
    endtask

    task automatic push_end(input int kind, input logic [2:0] v);
        exp_t e;
        e.kind = kind; e.vec = v; e.data = '0; e.gap = 0;
        eq.push_back(e);
    endtask

    task automatic push_rsp(input int dly, input logic ack);
        rsp_t r;
        r.dly = dly; r.ack = ack;
        rq.push_back(r);
    endtask

    task automatic wait_resp(input string nm, input int n, input int budget);
        int cnt;
        cnt = 0;
        for (int i = 0; i < budget && cnt < n; i++) begin
            @(posedge clk); #1;
            if ((done | err) != 0) cnt++;
        end
        chk(nm, cnt, n);
    endtask

    task automatic wait_mgo(input string nm, input int budget);
        for (int i = 0; i < budget && !mgo; i++) begin
            @(posedge clk); #1;
        end
        chk(nm, mgo, 1);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int i = 0; i < budget && (busy || eq.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_pending"}, eq.size(), 0);
    endtask

    // Controller model: ends each attempt after a scripted delay.
    initial begin
        rsp_t r;
        int   wc;
        bit   act;
        mend = 1'b0; mack = 1'b0; act = 0; wc = 0;
        r.dly = 0; r.ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            mend = 1'b0; mack = 1'b0;
            if (!reset) begin
                act = 0;
            end else if (act) begin
                if (wc >= r.dly) begin
                    mend = 1'b1; mack = r.ack; act = 0;
                end else begin
                    wc++;
                end
            end else if (mgo && rq.size() != 0) begin
                r = rq.pop_front(); act = 1; wc = 1;
            end
        end
    end

    // Monitor: compares every mgo start and done/err pulse against the queue.
    initial begin
        exp_t e;
        int   low;
        logic mgo_d;
        low = 0; mgo_d = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                low = 0; mgo_d = 1'b0;
            end else begin
                if (mgo && !mgo_d) begin
                    if (eq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_go: grant %0h data %0h", grant, i2c_data);
                    end else begin
                        e = eq.pop_front();
                        chk("go_kind", e.kind, 0);
                        chk("go_grant", grant, e.vec);
                        chk("go_data", i2c_data, e.data);
                        if (e.gap > 0) chk("go_gap", low, e.gap);
                    end
                end
                if ((done | err) != 0) begin
                    if (eq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pulse: done %0h err %0h", done, err);
                    end else begin
                        e = eq.pop_front();
                        chk("pulse_done", done, (e.kind == 1) ? e.vec : 3'b000);
                        chk("pulse_err", err, (e.kind == 2) ? e.vec : 3'b000);
                    end
                end
                low = mgo ? 0 : low + 1;
                mgo_d = mgo;
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; req = '0;
        req_data = {D2, D1, D0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mgo", mgo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", i2c_data, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single request, ACK after 20 cycles
        push_rsp(20, 1'b1);
        push_go(3'b001, D0, 0);
        push_end(1, 3'b001);
        req = 3'b001;
        @(posedge clk); #1;
        chk("t1_load_grant", grant, 3'b001);
        chk("t1_load_mgo", mgo, 0);
        chk("t1_load_busy", busy, 1);
        @(posedge clk); #1;
        chk("t1_mgo_rise", mgo, 1);
        wait_resp("t1_done_seen", 1, 100);
        req = '0;
        chk("t1_gap0_grant", grant, 3'b001);
        @(posedge clk); #1;
        chk("t1_gap1_grant", grant, 3'b001);
        @(posedge clk); #1;
        chk("t1_idle_grant", grant, 3'b000);
        wait_idle("t1_idle", 20);

        // All requesting; rr_ptr is 1 after the first transfer
        repeat (4) push_rsp(3, 1'b1);
        push_go(3'b010, D1, 0); push_end(1, 3'b010);
        push_go(3'b100, D2, 4); push_end(1, 3'b100);
        push_go(3'b001, D0, 4); push_end(1, 3'b001);
        push_go(3'b010, D1, 4); push_end(1, 3'b010);
        req = 3'b111;
        wait_resp("t2_four_done", 4, 400);
        req = '0;
        wait_idle("t2_idle", 40);

        // NACK on every attempt: four starts then err
        repeat (4) push_rsp(2, 1'b0);
        push_go(3'b010, D1, 0);
        repeat (3) push_go(3'b010, D1, 3);
        push_end(2, 3'b010);
        req = 3'b010;
        wait_resp("t3_err_seen", 1, 300);
        req = '0;
        wait_idle("t3_idle", 40);

        // Hung controller, then reset while in WAIT_END
        push_go(3'b100, D2, 0);
        req = 3'b100;
        wait_mgo("t5_mgo_up", 20);
        repeat (40) @(posedge clk);
        #1;
        chk("t5_hang_mgo", mgo, 1);
        chk("t5_hang_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_mgo", mgo, 0);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_pending", eq.size(), 0);
        req = 3'b110;
        push_rsp(4, 1'b1);
        push_go(3'b010, D1, 0);
        push_end(1, 3'b010);
        @(posedge clk); #1;
        reset = 1'b1;
        wait_resp("t5_done_seen", 1, 100);
        req = '0;
        wait_idle("t5_idle", 40);

        // NACK, NACK, ACK with data re-latched on retry
        push_rsp(3, 1'b0); push_rsp(3, 1'b0); push_rsp(5, 1'b1);
        push_go(3'b100, D2, 0);
        push_go(3'b100, D2B, 3);
        push_go(3'b100, D2B, 3);
        push_end(1, 3'b100);
        req = 3'b100;
        wait_mgo("t4_mgo_up", 20);
        req_data = {D2B, D1, D0};
        wait_resp("t4_done_seen", 1, 300);
        req = '0;
        chk("t4_no_err", err, 0);
        wait_idle("t4_idle", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
